// File: rtl/fifo_read_arbiter_pkg.sv
// Shared types and helpers for the FIFO read-side arbiter.
// Provides the FSM state encoding and a constant clog2 helper.
package fifo_read_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker.
// Ports: req (vector), ptr (start index) -> pick (one-hot), idx, found.
module rr_priority_pick
  import fifo_read_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan ptr, ptr+1, ... modulo N; first hit wins.
  always_comb begin : scan
    int j;
    logic [IW-1:0] jj;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < N; i++) begin
      j  = (int'(ptr) + i) % N;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found    = 1'b1;
        pick[jj] = 1'b1;
        idx      = jj;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin burst arbiter for the async FIFO read port.
// Ports: rclk, r_rst, req, empty -> r_en, grant, rd_valid, rd_id, busy.
module fifo_read_arbiter
  import fifo_read_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4,
  parameter int IDW       = 2
) (
  input  logic            rclk,
  input  logic            r_rst,
  input  logic [NREQ-1:0] req,
  input  logic            empty,
  output logic            r_en,
  output logic [NREQ-1:0] grant,
  output logic            rd_valid,
  output logic [IDW-1:0]  rd_id,
  output logic            busy
);

  localparam int CW = clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0]  LAST  = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0]  C_ONE = CW'(1);
  localparam logic [IDW-1:0] TOP   = IDW'(NREQ - 1);
  localparam logic [IDW-1:0] I_ONE = IDW'(1);

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  pick_idx;
  logic [NREQ-1:0] pick;
  logic            found;
  logic [CW-1:0]   beat_cnt;
  logic            own_req;
  logic            last_beat;
  logic            start;
  logic            leave;

  rr_priority_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .pick  (pick),
    .idx   (pick_idx),
    .found (found)
  );

  assign own_req = req[owner];

  // Outputs derived from registered state.
  always_comb begin
    busy = (state == BURST);
    r_en = busy & own_req & ~empty;
  end

  // Grant/release events.
  always_comb begin
    last_beat = r_en && (beat_cnt == LAST);
    start     = (state == IDLE) && found && !empty;
    leave     = busy && (!own_req || empty || last_beat);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = BURST;
      BURST: if (leave) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge r_rst) begin
    if (!r_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge rclk or negedge r_rst) begin
    if (!r_rst) begin
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      rd_valid <= r_en;
      rd_id    <= owner;
      if (start) begin
        grant    <= pick;
        owner    <= pick_idx;
        beat_cnt <= '0;
      end else if (busy) begin
        if (r_en)
          beat_cnt <= beat_cnt + C_ONE;
        // Pointer advances past the owner even on a partial burst.
        if (leave) begin
          grant  <= '0;
          rr_ptr <= (owner == TOP) ? '0 : owner + I_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter.
// Directed vector table, hand sequences and a random run vs a model.
module tb_fifo_read_arbiter;

  localparam int N  = 4;
  localparam int BL = 4;
  localparam int IW = 2;

  logic          rclk = 1'b0;
  logic          r_rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic          empty = 1'b1;
  logic          r_en;
  logic [N-1:0]  grant;
  logic          rd_valid;
  logic [IW-1:0] rd_id;
  logic          busy;

  fifo_read_arbiter #(
    .NREQ      (N),
    .BURST_LEN (BL),
    .IDW       (IW)
  ) dut (
    .rclk     (rclk),
    .r_rst    (r_rst),
    .req      (req),
    .empty    (empty),
    .r_en     (r_en),
    .grant    (grant),
    .rd_valid (rd_valid),
    .rd_id    (rd_id),
    .busy     (busy)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // Model: who owns the port (-1 none), beats taken, next start index.
  int m_owner;
  int m_beats;
  int m_ptr;
  int m_rdv;
  int m_rdid;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 0;
    m_rdv   = 0;
    m_rdid  = 0;
  endtask

  function automatic int model_ren(input logic [N-1:0] r, input logic e);
    if (m_owner < 0) return 0;
    return (r[m_owner[IW-1:0]] && !e) ? 1 : 0;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic e);
    int ren;
    int o;
    int c;
    bit ex;
    ren = model_ren(r, e);
    m_rdv = ren;
    if (ren != 0) m_rdid = m_owner;
    if (m_owner < 0) begin
      if (r != '0 && !e) begin
        for (int i = 0; i < N; i++) begin
          c = (m_ptr + i) % N;
          if (r[c[IW-1:0]]) begin
            m_owner = c;
            break;
          end
        end
        m_beats = 0;
      end
    end else begin
      o  = m_owner;
      ex = !r[o[IW-1:0]] || e || (ren != 0 && m_beats == BL - 1);
      if (ren != 0) m_beats++;
      if (ex) begin
        m_ptr   = (o + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic e);
    int eg;
    @(negedge rclk);
    req   = r;
    empty = e;
    #1;
    eg = (m_owner < 0) ? 0 : (1 << m_owner);
    chk("grant", int'(grant), eg);
    chk("r_en", int'(r_en), model_ren(r, e));
    chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
    chk("rd_valid", int'(rd_valid), m_rdv);
    if (m_rdv != 0) chk("rd_id", int'(rd_id), m_rdid);
    model_step(r, e);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    r_rst = 1'b0;
    req   = '0;
    empty = 1'b1;
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_r_en", int'(r_en), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_id", int'(rd_id), 0);
    chk("rst_busy", int'(busy), 0);
    model_reset();
    @(negedge rclk);
    r_rst = 1'b1;
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    logic         empty;
    logic [N-1:0] grant;
    logic         ren;
    logic         rdv;
  } vec_t;

  vec_t tv[14];

  initial begin
    int order[$];
    logic [N-1:0] prev;
    logic [N-1:0] rq;
    logic         e;
    int nb;

    model_reset();

    // Single consumer, then empty held at arbitration.
    tv[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1};
    tv[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1};
    tv[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1};
    tv[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0};
    tv[10] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0};
    tv[11] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0};
    tv[12] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0};
    tv[13] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      if (tv[i].rst) do_reset();
      step(tv[i].req, tv[i].empty);
      chk("tv_grant", int'(grant), int'(tv[i].grant));
      chk("tv_r_en", int'(r_en), int'(tv[i].ren));
      chk("tv_rd_valid", int'(rd_valid), int'(tv[i].rdv));
      if (tv[i].rdv) chk("tv_rd_id", int'(rd_id), 0);
    end

    // All consumers requesting: rotation 0,1,2,3,0.
    do_reset();
    prev = '0;
    for (int c = 0; c < 25; c++) begin
      step(4'b1111, 1'b0);
      if (grant != '0 && prev == '0) begin
        for (int k = 0; k < N; k++)
          if (grant[k]) order.push_back(k);
      end
      prev = grant;
    end
    chk("rr_order_len", order.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < order.size()) chk("rr_order", order[k], k % N);

    // Empty mid-burst on consumer 2, then consumer 3 follows.
    do_reset();
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1100, 1'b1);
    chk("t3_r_en_empty", int'(r_en), 0);
    step(4'b1100, 1'b0);
    chk("t3_idle", int'(grant), 0);
    step(4'b1100, 1'b0);
    chk("t3_next", int'(grant), 8);

    // Consumer 1 withdraws after one beat; full burst follows.
    do_reset();
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    chk("t4_r_en_drop", int'(r_en), 0);
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    chk("t4_next", int'(grant), 4);
    nb = int'(r_en);
    for (int c = 0; c < 4; c++) begin
      step(4'b0110, 1'b0);
      nb += int'(r_en);
    end
    chk("t4_beats", nb, BL);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    #1;
    r_rst = 1'b0;
    req   = '0;
    empty = 1'b1;
    #1;
    chk("t5_grant", int'(grant), 0);
    chk("t5_r_en", int'(r_en), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_rd_valid", int'(rd_valid), 0);
    model_reset();
    @(negedge rclk);
    r_rst = 1'b1;
    step(4'b1010, 1'b0);
    chk("t5_arb", int'(grant), 0);
    step(4'b1010, 1'b0);
    chk("t5_first", int'(grant), 2);

    // Random traffic against the model.
    do_reset();
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      e = ($urandom_range(0, 4) == 0);
      step(rq, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
